// File: rtl/fifo_wr_arb_pkg.sv
// Shared types for the FIFO write arbiter: FSM state encoding and default widths.
package fifo_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam int FIFO_DATA_WIDTH = 8;
    localparam int FIFO_NUM_REQ    = 4;
    localparam int FIFO_MAX_REQ    = 8;

endpackage

// File: rtl/fifo_wr_arb_if.sv
// Requester/FIFO-side bundle of the write arbiter; master drives requests, slave is the arbiter.
interface fifo_wr_arb_if
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int NUM_REQ    = FIFO_NUM_REQ
);
    // A beat moves in the cycle where i_req_valid[k] and o_req_ready[k] are both high;
    // ready is only raised together with o_fifo_wr, never while i_fifo_full is high.
    logic [NUM_REQ-1:0]            i_req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data;
    logic [NUM_REQ-1:0]            i_req_last;
    logic [NUM_REQ-1:0]            o_req_ready;
    logic                          i_fifo_full;
    logic                          o_fifo_wr;
    logic [DATA_WIDTH-1:0]         o_fifo_wr_data;

    modport master (
        output i_req_valid, i_req_data, i_req_last, i_fifo_full,
        input  o_req_ready, o_fifo_wr, o_fifo_wr_data
    );

    modport slave (
        input  i_req_valid, i_req_data, i_req_last, i_fifo_full,
        output o_req_ready, o_fifo_wr, o_fifo_wr_data
    );

endinterface

// File: rtl/fifo_wr_arb_rr_pick.sv
// Combinational round-robin picker: first set bit of valid at or after start, wrapping.
module rr_pick #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] start,
    output logic [IW-1:0] idx,
    output logic          found
);

    logic [IW-1:0] probe;

    always_comb begin
        idx   = '0;
        found = 1'b0;
        probe = start;
        for (int i = 0; i < N; i++) begin
            if (!found && valid[probe]) begin
                idx   = probe;
                found = 1'b1;
            end
            probe = (probe == IW'(N - 1)) ? '0 : probe + 1'b1;
        end
    end

endmodule

// File: rtl/fifo_wr_arb.sv
// Multi-requester FIFO write arbiter with message locking.
// Define FIFO_WR_ARB_PRIO_EN to give requester 0 absolute priority while idle.
module fifo_wr_arb
    import fifo_pkg::*;
#(
    parameter  int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter  int NUM_REQ    = FIFO_NUM_REQ,
    localparam int ID_WIDTH   = $clog2(NUM_REQ)
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    fifo_wr_arb_if.slave        bus,
    output logic                o_locked,
    output logic [ID_WIDTH-1:0] o_grant_id,
    output state_t              o_state
);

    state_t                state, state_nxt;
    logic [ID_WIDTH-1:0]   rr_ptr, rr_nxt;
    logic [ID_WIDTH-1:0]   owner, owner_nxt;
    logic [ID_WIDTH-1:0]   pick_idx;
    logic                  pick_found;
    logic [ID_WIDTH-1:0]   sel_idx;
    logic                  sel_valid;
    logic                  sel_last;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  xfer;

    function automatic logic [ID_WIDTH-1:0] next_idx(input logic [ID_WIDTH-1:0] i);
        return (i == ID_WIDTH'(NUM_REQ - 1)) ? '0 : i + 1'b1;
    endfunction

    rr_pick #(.N(NUM_REQ)) u_rr_pick (
        .valid (bus.i_req_valid),
        .start (rr_ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // Locked messages bypass arbitration entirely: only the owner is ever looked at.
    always_comb begin
        sel_idx   = owner;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        if (state == IDLE) begin
`ifdef FIFO_WR_ARB_PRIO_EN
            sel_idx = bus.i_req_valid[0] ? '0 : pick_idx;
`else
            sel_idx = pick_idx;
`endif
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            if (sel_idx == ID_WIDTH'(k)) begin
                sel_valid = bus.i_req_valid[k];
                sel_last  = bus.i_req_last[k];
                sel_data  = bus.i_req_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        if (state == IDLE && !pick_found) sel_valid = 1'b0;
    end

    assign xfer = sel_valid && !bus.i_fifo_full && i_rst_n;

    always_comb begin
        state_nxt = state;
        rr_nxt    = rr_ptr;
        owner_nxt = owner;
        if (xfer) begin
            case (state)
                IDLE: begin
                    if (sel_last) begin
                        rr_nxt = next_idx(sel_idx);
                    end else begin
                        state_nxt = LOCKED;
                        owner_nxt = sel_idx;
                    end
                end
                LOCKED: begin
                    if (sel_last) begin
                        state_nxt = IDLE;
                        rr_nxt    = next_idx(owner);
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            owner      <= '0;
            o_grant_id <= '0;
        end else begin
            state  <= state_nxt;
            rr_ptr <= rr_nxt;
            owner  <= owner_nxt;
            if (xfer) o_grant_id <= sel_idx;
        end
    end

    always_comb begin
        bus.o_req_ready = '0;
        if (xfer) bus.o_req_ready[sel_idx] = 1'b1;
        bus.o_fifo_wr      = xfer;
        bus.o_fifo_wr_data = sel_data;
        o_locked           = (state == LOCKED);
        o_state            = state;
    end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Bench for fifo_wr_arb: vector table, directed message sequences and a randomized model check.
module tb_fifo_wr_arb;
    import fifo_pkg::*;

    localparam int DW = 8;
    localparam int NR = 4;
    localparam int IW = 2;

    logic          i_clk   = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          o_locked;
    logic [IW-1:0] o_grant_id;
    state_t        o_state;

    fifo_wr_arb_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

    fifo_wr_arb #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .bus        (bus),
        .o_locked   (o_locked),
        .o_grant_id (o_grant_id),
        .o_state    (o_state)
    );

    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad   = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] got_q[$];

    // reference model state
    int            m_rr;
    int            m_owner;
    bit            m_locked;
    logic [IW-1:0] m_gid;

    typedef struct {
        logic [NR-1:0] v;
        logic [NR-1:0] l;
        logic          f;
        logic          wr;
        logic [NR-1:0] rdy;
        logic [IW-1:0] gid;
        logic          lk;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic logic [NR*DW-1:0] pack4(input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                                               input logic [DW-1:0] d2, input logic [DW-1:0] d3);
        return {d3, d2, d1, d0};
    endfunction

    function automatic logic [DW-1:0] word(input logic [NR*DW-1:0] d, input int k);
        return d[k*DW +: DW];
    endfunction

    // Called at posedge+1; checks combinational outputs mid-cycle, then registered ones after the edge.
    task automatic apply(input logic [NR-1:0] v, input logic [NR*DW-1:0] d, input logic [NR-1:0] l,
                         input logic f, input logic e_wr, input logic [NR-1:0] e_rdy,
                         input logic [DW-1:0] e_data, input logic [IW-1:0] e_gid,
                         input logic e_lk, input string tag);
        bus.i_req_valid = v;
        bus.i_req_data  = d;
        bus.i_req_last  = l;
        bus.i_fifo_full = f;
        #2;
        check({tag, ".wr"}, 32'(bus.o_fifo_wr), 32'(e_wr));
        check({tag, ".ready"}, 32'(bus.o_req_ready), 32'(e_rdy));
        if (e_wr) check({tag, ".data"}, 32'(bus.o_fifo_wr_data), 32'(e_data));
        if (bus.o_fifo_wr) got_q.push_back(bus.o_fifo_wr_data);
        @(posedge i_clk);
        #1;
        check({tag, ".gid"}, 32'(o_grant_id), 32'(e_gid));
        check({tag, ".locked"}, 32'(o_locked), 32'(e_lk));
        check({tag, ".state"}, 32'(o_state), 32'(e_lk));
    endtask

    task automatic model_reset();
        m_rr     = 0;
        m_owner  = 0;
        m_locked = 1'b0;
        m_gid    = '0;
    endtask

    task automatic do_reset();
        i_rst_n         = 1'b0;
        bus.i_req_valid = '1;
        bus.i_req_data  = '0;
        bus.i_req_last  = '1;
        bus.i_fifo_full = 1'b0;
        #1;
        check("reset.wr", 32'(bus.o_fifo_wr), 32'd0);
        check("reset.ready", 32'(bus.o_req_ready), 32'd0);
        check("reset.locked", 32'(o_locked), 32'd0);
        check("reset.gid", 32'(o_grant_id), 32'd0);
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        model_reset();
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic sb_compare(input string tag);
        check({tag, ".count"}, 32'(got_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && got_q.size() > 0)
            check({tag, ".beat"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic rand_phase(input int n);
        logic [NR-1:0]    v;
        logic [NR*DW-1:0] d;
        logic [NR-1:0]    l;
        logic             f;
        logic             e_wr;
        logic [NR-1:0]    e_rdy;
        bit               cand;
        int               sel;
        int               k;
        for (int c = 0; c < n; c++) begin
            v    = NR'($urandom_range(0, 15));
            d    = $urandom();
            l    = NR'($urandom_range(0, 15) | $urandom_range(0, 15));
            f    = ($urandom_range(0, 4) == 0);
            cand = 1'b0;
            sel  = 0;
            if (m_locked) begin
                sel  = m_owner;
                cand = v[sel];
            end else begin
`ifdef FIFO_WR_ARB_PRIO_EN
                if (v[0]) begin
                    sel  = 0;
                    cand = 1'b1;
                end
`endif
                for (int off = 0; off < NR; off++) begin
                    k = (m_rr + off) % NR;
                    if (!cand && v[k]) begin
                        sel  = k;
                        cand = 1'b1;
                    end
                end
            end
            e_wr  = cand && !f;
            e_rdy = e_wr ? NR'(1 << sel) : '0;
            if (e_wr) begin
                m_gid = IW'(sel);
                if (l[sel]) begin
                    m_locked = 1'b0;
                    m_rr     = (sel + 1) % NR;
                end else begin
                    m_locked = 1'b1;
                    m_owner  = sel;
                end
            end
            apply(v, d, l, f, e_wr, e_rdy, e_wr ? word(d, sel) : '0, m_gid, m_locked, "rand");
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        logic [NR*DW-1:0] dstd;
`ifndef FIFO_WR_ARB_PRIO_EN
        vec_t tbl[18];
        tbl[0]  = '{4'b1111, 4'b1111, 1'b0, 1'b1, 4'b0001, 2'd0, 1'b0};
        tbl[1]  = '{4'b1111, 4'b1111, 1'b0, 1'b1, 4'b0010, 2'd1, 1'b0};
        tbl[2]  = '{4'b1111, 4'b1111, 1'b0, 1'b1, 4'b0100, 2'd2, 1'b0};
        tbl[3]  = '{4'b1111, 4'b1111, 1'b0, 1'b1, 4'b1000, 2'd3, 1'b0};
        tbl[4]  = '{4'b1111, 4'b1111, 1'b0, 1'b1, 4'b0001, 2'd0, 1'b0};
        tbl[5]  = '{4'b1111, 4'b1111, 1'b0, 1'b1, 4'b0010, 2'd1, 1'b0};
        tbl[6]  = '{4'b1111, 4'b1111, 1'b0, 1'b1, 4'b0100, 2'd2, 1'b0};
        tbl[7]  = '{4'b1111, 4'b1111, 1'b0, 1'b1, 4'b1000, 2'd3, 1'b0};
        tbl[8]  = '{4'b1111, 4'b1111, 1'b1, 1'b0, 4'b0000, 2'd3, 1'b0};
        tbl[9]  = '{4'b0000, 4'b1111, 1'b0, 1'b0, 4'b0000, 2'd3, 1'b0};
        tbl[10] = '{4'b1010, 4'b0000, 1'b0, 1'b1, 4'b0010, 2'd1, 1'b1};
        tbl[11] = '{4'b1101, 4'b1111, 1'b0, 1'b0, 4'b0000, 2'd1, 1'b1};
        tbl[12] = '{4'b1111, 4'b1111, 1'b1, 1'b0, 4'b0000, 2'd1, 1'b1};
        tbl[13] = '{4'b0010, 4'b0010, 1'b0, 1'b1, 4'b0010, 2'd1, 1'b0};
        tbl[14] = '{4'b1011, 4'b1111, 1'b0, 1'b1, 4'b1000, 2'd3, 1'b0};
        tbl[15] = '{4'b1011, 4'b1111, 1'b0, 1'b1, 4'b0001, 2'd0, 1'b0};
        tbl[16] = '{4'b1011, 4'b1111, 1'b0, 1'b1, 4'b0010, 2'd1, 1'b0};
        tbl[17] = '{4'b1001, 4'b1111, 1'b0, 1'b1, 4'b1000, 2'd3, 1'b0};
`endif
        dstd = pack4(8'hA0, 8'hA1, 8'hA2, 8'hA3);

        do_reset();
`ifndef FIFO_WR_ARB_PRIO_EN
        for (int i = 0; i < 18; i++)
            apply(tbl[i].v, dstd, tbl[i].l, tbl[i].f, tbl[i].wr, tbl[i].rdy,
                  tbl[i].wr ? 8'hA0 + 8'(tbl[i].gid) : 8'h00, tbl[i].gid, tbl[i].lk, "tbl");
`else
        for (int i = 0; i < 6; i++)
            apply(4'b1001, dstd, 4'b1111, 1'b0, 1'b1, 4'b0001, 8'hA0, 2'd0, 1'b0, "prio");
`endif

        // three-beat message from req1 holds off req2
        do_reset();
        apply(4'b0110, pack4(8'h00, 8'h11, 8'h22, 8'h00), 4'b0100, 1'b0, 1'b1, 4'b0010, 8'h11, 2'd1, 1'b1, "msg.b1");
        apply(4'b0110, pack4(8'h00, 8'h12, 8'h22, 8'h00), 4'b0100, 1'b0, 1'b1, 4'b0010, 8'h12, 2'd1, 1'b1, "msg.b2");
        apply(4'b0110, pack4(8'h00, 8'h13, 8'h22, 8'h00), 4'b0110, 1'b0, 1'b1, 4'b0010, 8'h13, 2'd1, 1'b0, "msg.b3");
        apply(4'b0100, pack4(8'h00, 8'h00, 8'h22, 8'h00), 4'b0100, 1'b0, 1'b1, 4'b0100, 8'h22, 2'd2, 1'b0, "msg.r2");
        exp_q = '{8'h11, 8'h12, 8'h13, 8'h22};
        sb_compare("msg.sb");

        // FIFO full for three cycles in the middle of req0's message
        do_reset();
        apply(4'b0001, pack4(8'h31, 8'h00, 8'h00, 8'h00), 4'b0000, 1'b0, 1'b1, 4'b0001, 8'h31, 2'd0, 1'b1, "full.b1");
        for (int i = 0; i < 3; i++)
            apply(4'b0001, pack4(8'h32, 8'h00, 8'h00, 8'h00), 4'b0000, 1'b1, 1'b0, 4'b0000, 8'h00, 2'd0, 1'b1, "full.hold");
        apply(4'b0001, pack4(8'h32, 8'h00, 8'h00, 8'h00), 4'b0000, 1'b0, 1'b1, 4'b0001, 8'h32, 2'd0, 1'b1, "full.b2");
        apply(4'b0001, pack4(8'h33, 8'h00, 8'h00, 8'h00), 4'b0001, 1'b0, 1'b1, 4'b0001, 8'h33, 2'd0, 1'b0, "full.b3");
        exp_q = '{8'h31, 8'h32, 8'h33};
        sb_compare("full.sb");

        // owner goes quiet while locked; others must wait
        do_reset();
        apply(4'b0010, pack4(8'h00, 8'h51, 8'h62, 8'h63), 4'b0000, 1'b0, 1'b1, 4'b0010, 8'h51, 2'd1, 1'b1, "gap.b1");
        for (int i = 0; i < 2; i++)
            apply(4'b1100, pack4(8'h00, 8'h00, 8'h62, 8'h63), 4'b1111, 1'b0, 1'b0, 4'b0000, 8'h00, 2'd1, 1'b1, "gap.idle");
        apply(4'b1110, pack4(8'h00, 8'h52, 8'h62, 8'h63), 4'b1111, 1'b0, 1'b1, 4'b0010, 8'h52, 2'd1, 1'b0, "gap.b2");
        apply(4'b1100, pack4(8'h00, 8'h00, 8'h62, 8'h63), 4'b1111, 1'b0, 1'b1, 4'b0100, 8'h62, 2'd2, 1'b0, "gap.r2");
        exp_q = '{8'h51, 8'h52, 8'h62};
        sb_compare("gap.sb");

        // reset while locked on req2
        do_reset();
        apply(4'b0100, dstd, 4'b0000, 1'b0, 1'b1, 4'b0100, 8'hA2, 2'd2, 1'b1, "rst.lock");
        i_rst_n         = 1'b0;
        bus.i_req_valid = 4'b1111;
        #1;
        check("rst.locked", 32'(o_locked), 32'd0);
        check("rst.gid", 32'(o_grant_id), 32'd0);
        check("rst.wr", 32'(bus.o_fifo_wr), 32'd0);
        check("rst.ready", 32'(bus.o_req_ready), 32'd0);
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        model_reset();
        apply(4'b0101, dstd, 4'b1111, 1'b0, 1'b1, 4'b0001, 8'hA0, 2'd0, 1'b0, "rst.first");
        apply(4'b0100, dstd, 4'b1111, 1'b0, 1'b1, 4'b0100, 8'hA2, 2'd2, 1'b0, "rst.second");

        do_reset();
        rand_phase(300);
        do_reset();
        rand_phase(300);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the width of each requester's data word and of the FIFO write data.
REQ-002 Parameter NUM_REQ, default 4, SHALL set the requester count; legal range 2..8; ID_WIDTH = $clog2(NUM_REQ).
REQ-003 i_clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 i_rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 i_req_valid  in  NUM_REQ  SHALL carry the per-requester "beat offered" flags.
REQ-006 i_req_data  in  NUM_REQ*DATA_WIDTH  SHALL carry the flattened per-requester beats; requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-007 i_req_last  in  NUM_REQ  SHALL mark the final beat of a requester's message.
REQ-008 o_req_ready  out  NUM_REQ  SHALL be the one-hot-or-zero transfer acknowledge to each requester.
REQ-009 i_fifo_full  in  1  SHALL be the full flag of the downstream FIFO.
REQ-010 o_fifo_wr  out  1  SHALL be the FIFO write strobe.
REQ-011 o_fifo_wr_data  out  DATA_WIDTH  SHALL be the FIFO write data.
REQ-012 o_locked  out  1  SHALL be high while a multi-beat message owns the FIFO.
REQ-013 o_grant_id  out  ID_WIDTH  SHALL be the registered index of the most recent granted requester.

Function
REQ-014 A transfer SHALL occur in a cycle iff the selected requester has valid high and i_fifo_full is low; in that cycle o_fifo_wr=1, its o_req_ready bit=1, and o_fifo_wr_data equals its data (combinational, zero latency).
REQ-015 o_fifo_wr SHALL never be high while i_fifo_full is high; at most one o_req_ready bit SHALL be high per cycle, and only together with o_fifo_wr.
REQ-016 FSM states SHALL be IDLE and LOCKED.
REQ-017 In IDLE, selection SHALL be round-robin: the first valid requester at or after rr_ptr, wrapping NUM_REQ-1 -> 0.
REQ-018 IDLE transfer with last=1 SHALL stay in IDLE and set rr_ptr to (granted+1) mod NUM_REQ.
REQ-019 IDLE transfer with last=0 SHALL move to LOCKED, registering owner = granted.
REQ-020 In LOCKED, only owner SHALL be selectable; other requesters' ready SHALL stay low even if the owner's valid is low.
REQ-021 LOCKED transfer with last=1 SHALL return to IDLE and set rr_ptr to (owner+1) mod NUM_REQ; last=0 SHALL stay LOCKED.
REQ-022 With i_fifo_full high, state, rr_ptr and owner SHALL hold; no beat is lost or duplicated.
REQ-023 No valid requester in IDLE SHALL leave all state unchanged.
REQ-024 o_grant_id SHALL update on each transfer edge to the granted index and hold otherwise.

Reset
REQ-025 Asserting i_rst_n low SHALL immediately force IDLE, rr_ptr=0, owner=0, o_grant_id=0, o_locked=0; o_fifo_wr and o_req_ready SHALL be 0 while reset is asserted.
REQ-026 Reset mid-message SHALL abandon the lock; the first cycle after release arbitrates from requester 0.

Configuration
REQ-027 Macro FIFO_WR_ARB_PRIO_EN defined: in IDLE, requester 0 SHALL win whenever valid, regardless of rr_ptr; LOCKED behaviour is unchanged.
REQ-028 Macro undefined: pure round-robin per REQ-017.

Structure
REQ-029 State encodings (IDLE=0, LOCKED=1) SHALL live in shared package fifo_pkg alongside FIFO width constants.
REQ-030 Round-robin pick (valid vector, start pointer -> index, found) SHALL be a combinational sub-module rr_pick.

Verification
REQ-031 NUM_REQ=4, all valid, last=1, full=0 for 8 cycles -> grants 0,1,2,3,0,1,2,3; 8 FIFO writes.
REQ-032 Req1 sends 3 beats 0x11,0x12,0x13 (last on 3rd), req2 valid throughout -> FIFO receives 0x11,0x12,0x13 then req2's beat; o_locked high for 2 cycles.
REQ-033 Full asserted 3 cycles mid-message of req0 -> o_fifo_wr=0, ready=0 for those cycles; message resumes, no beat dropped.
REQ-034 Owner valid drops for 2 cycles while LOCKED, others valid -> no writes; others not granted until owner's last beat.
REQ-035 Reset asserted in LOCKED with owner=2 -> o_locked=0 at once; after release, req0 and req2 valid -> req0 granted first.
REQ-036 With FIFO_WR_ARB_PRIO_EN, req0 and req3 continuously valid, last=1 -> req0 granted every cycle.
